// File: rtl/qpu_mcu_meas_resp_pkg.sv
// -----------------------------------------------------------------------------
// qpu_mcu_meas_resp_pkg
// Shared definitions for the measure-response collector: default qubit count,
// timeout counter width, pending-list depth and the collector FSM encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package qpu_mcu_meas_resp_pkg;

    localparam int QPU_QUBIT_NUM  = 12;
    localparam int QPU_TMO_W      = 16;
    localparam int QPU_LIST_DEPTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_RETURN  = 2'd2
    } meas_state_e;

    // Pointer width that never collapses to zero bits for a depth of one.
    function automatic int clog2_min1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/qpu_mcu_meas_resp_list_fifo.sv
// -----------------------------------------------------------------------------
// qpu_mcu_meas_resp_list_fifo
// Pending-measure-list FIFO. Holds qubit masks of issued measure instructions
// until the collector takes them.
// Ports:
//   clk          - rising-edge clock
//   rst          - synchronous active-high reset
//   i_push       - write request (accepted only while o_ready=1)
//   i_push_data  - mask to store
//   i_pop        - read request (ignored while empty)
//   o_head       - mask at the head of the queue
//   o_empty      - queue holds no entries
//   o_ready      - registered "not full"; 0 during reset
// -----------------------------------------------------------------------------
module qpu_mcu_meas_resp_list_fifo
    import qpu_mcu_meas_resp_pkg::*;
#(
    parameter int WIDTH = QPU_QUBIT_NUM,
    parameter int DEPTH = QPU_LIST_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_empty,
    output logic             o_ready
);

    localparam int PTR_W = clog2_min1(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_ready;

    logic             w_push_ok;
    logic             w_pop_ok;
    logic [CNT_W-1:0] w_count_next;

    // Wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? PTR_W'(0) : ptr + PTR_W'(1);
    endfunction

    assign w_push_ok = i_push & r_ready;
    assign w_pop_ok  = i_pop & (r_count != CNT_W'(0));
    assign o_head    = r_mem[r_rd_ptr];
    assign o_empty   = (r_count == CNT_W'(0));
    assign o_ready   = r_ready;

    // Occupancy after this cycle's push/pop (both may happen together).
    always_comb begin
        w_count_next = r_count;
        if (w_push_ok && !w_pop_ok) begin
            w_count_next = r_count + CNT_W'(1);
        end else if (!w_push_ok && w_pop_ok) begin
            w_count_next = r_count - CNT_W'(1);
        end else begin
            w_count_next = r_count;
        end
    end

    // Storage, pointers, occupancy and the registered ready flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= PTR_W'(0);
            r_rd_ptr <= PTR_W'(0);
            r_count  <= CNT_W'(0);
            r_ready  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {WIDTH{1'b0}};
            end
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= ptr_inc(r_wr_ptr);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            r_count <= w_count_next;
            // Ready reflects the occupancy the queue will have next cycle.
            r_ready <= (w_count_next != CNT_W'(DEPTH));
        end
    end

endmodule

// File: rtl/qpu_mcu_meas_resp.sv
// -----------------------------------------------------------------------------
// qpu_mcu_meas_resp
// Collects per-qubit readout results for issued measure instructions and
// returns them (with the measured list) to the regfile/OITF.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   meas_req_valid/ready     - push of a measured-qubit mask into the FIFO
//   meas_req_list            - qubit mask (all-zero masks are dropped)
//   rdout_valid/rdout_data   - per-qubit readout strobe and result bit
//   tmo_cfg                  - collect timeout in cycles, 0 = no timeout
//   mcu_measure_o_wen/ready  - result return handshake
//   mcu_measure_o_data/list  - collected results and their list
//   mcu_measure_o_tmo        - return forced by timeout
//   stray_o                  - pulse for a strobe nobody is waiting for
// -----------------------------------------------------------------------------
module qpu_mcu_meas_resp
    import qpu_mcu_meas_resp_pkg::*;
#(
    parameter int QUBIT_NUM  = QPU_QUBIT_NUM,
    parameter int LIST_DEPTH = QPU_LIST_DEPTH,
    parameter int TMO_W      = QPU_TMO_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 meas_req_valid,
    output logic                 meas_req_ready,
    input  logic [QUBIT_NUM-1:0] meas_req_list,
    input  logic [QUBIT_NUM-1:0] rdout_valid,
    input  logic [QUBIT_NUM-1:0] rdout_data,
    input  logic [TMO_W-1:0]     tmo_cfg,
    output logic                 mcu_measure_o_wen,
    input  logic                 mcu_measure_o_ready,
    output logic [QUBIT_NUM-1:0] mcu_measure_o_data,
    output logic [QUBIT_NUM-1:0] mcu_measure_o_list,
    output logic                 mcu_measure_o_tmo,
    output logic                 stray_o
);

    meas_state_e          r_state;
    meas_state_e          w_state_next;

    logic [QUBIT_NUM-1:0] r_list;
    logic [QUBIT_NUM-1:0] r_got;
    logic [QUBIT_NUM-1:0] r_data;
    logic [TMO_W-1:0]     r_cnt;

    logic                 r_wen;
    logic [QUBIT_NUM-1:0] r_o_data;
    logic [QUBIT_NUM-1:0] r_o_list;
    logic                 r_o_tmo;
    logic                 r_stray;

    logic                 w_push;
    logic                 w_pop;
    logic [QUBIT_NUM-1:0] w_head;
    logic                 w_fifo_empty;
    logic                 w_fifo_ready;

    logic [QUBIT_NUM-1:0] w_hit;
    logic [QUBIT_NUM-1:0] w_got_next;
    logic [QUBIT_NUM-1:0] w_data_next;
    logic                 w_complete;
    logic                 w_timeout;
    logic                 w_accept;
    logic                 w_stray_next;

    logic                 w_wen_next;
    logic [QUBIT_NUM-1:0] w_o_data_next;
    logic [QUBIT_NUM-1:0] w_o_list_next;
    logic                 w_o_tmo_next;

    assign w_push = meas_req_valid & (|meas_req_list);
    assign w_pop  = (r_state == ST_IDLE) & ~w_fifo_empty;

    qpu_mcu_meas_resp_list_fifo #(
        .WIDTH (QUBIT_NUM),
        .DEPTH (LIST_DEPTH)
    ) u_list_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (meas_req_list),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_empty     (w_fifo_empty),
        .o_ready     (w_fifo_ready)
    );

    // Only the first strobe of an awaited qubit is taken; repeats are dropped.
    assign w_hit       = rdout_valid & r_list & ~r_got;
    assign w_got_next  = r_got | w_hit;
    assign w_data_next = (r_data & ~w_hit) | (rdout_data & w_hit);
    // Completion looks at this cycle's strobes so the return costs one cycle.
    assign w_complete  = (w_got_next == r_list);
    assign w_timeout   = (tmo_cfg != {TMO_W{1'b0}}) && (r_cnt >= (tmo_cfg - TMO_W'(1)));
    assign w_accept    = r_wen & mcu_measure_o_ready;

    // Stray: outside the active list while collecting, or any strobe otherwise.
    always_comb begin
        w_stray_next = 1'b0;
        if (r_state == ST_COLLECT) begin
            w_stray_next = |(rdout_valid & ~r_list);
        end else begin
            w_stray_next = |rdout_valid;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!w_fifo_empty) begin
                    w_state_next = ST_COLLECT;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_COLLECT: begin
                if (w_complete || w_timeout) begin
                    w_state_next = ST_RETURN;
                end else begin
                    w_state_next = ST_COLLECT;
                end
            end
            ST_RETURN: begin
                if (w_accept) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_RETURN;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // FSM output logic: next values of the registered return interface.
    always_comb begin
        w_wen_next    = 1'b0;
        w_o_data_next = {QUBIT_NUM{1'b0}};
        w_o_list_next = {QUBIT_NUM{1'b0}};
        w_o_tmo_next  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_wen_next = 1'b0;
            end
            ST_COLLECT: begin
                if (w_complete || w_timeout) begin
                    w_wen_next    = 1'b1;
                    w_o_data_next = w_data_next & r_list;
                    w_o_list_next = r_list;
                    // A list finishing on the timeout cycle is a normal return.
                    w_o_tmo_next  = ~w_complete;
                end else begin
                    w_wen_next = 1'b0;
                end
            end
            ST_RETURN: begin
                if (w_accept) begin
                    w_wen_next = 1'b0;
                end else begin
                    w_wen_next    = r_wen;
                    w_o_data_next = r_o_data;
                    w_o_list_next = r_o_list;
                    w_o_tmo_next  = r_o_tmo;
                end
            end
            default: begin
                w_wen_next = 1'b0;
            end
        endcase
    end

    // Registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wen    <= 1'b0;
            r_o_data <= {QUBIT_NUM{1'b0}};
            r_o_list <= {QUBIT_NUM{1'b0}};
            r_o_tmo  <= 1'b0;
            r_stray  <= 1'b0;
        end else begin
            r_wen    <= w_wen_next;
            r_o_data <= w_o_data_next;
            r_o_list <= w_o_list_next;
            r_o_tmo  <= w_o_tmo_next;
            r_stray  <= w_stray_next;
        end
    end

    // Active list, got/data masks and the saturating collect-cycle counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_list <= {QUBIT_NUM{1'b0}};
            r_got  <= {QUBIT_NUM{1'b0}};
            r_data <= {QUBIT_NUM{1'b0}};
            r_cnt  <= {TMO_W{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_fifo_empty) begin
                        r_list <= w_head;
                        r_got  <= {QUBIT_NUM{1'b0}};
                        r_data <= {QUBIT_NUM{1'b0}};
                        r_cnt  <= {TMO_W{1'b0}};
                    end
                end
                ST_COLLECT: begin
                    r_got  <= w_got_next;
                    r_data <= w_data_next;
                    if (r_cnt != {TMO_W{1'b1}}) begin
                        r_cnt <= r_cnt + TMO_W'(1);
                    end
                end
                ST_RETURN: begin
                    r_got <= r_got;
                end
                default: begin
                    r_got <= r_got;
                end
            endcase
        end
    end

    assign meas_req_ready     = w_fifo_ready;
    assign mcu_measure_o_wen  = r_wen;
    assign mcu_measure_o_data = r_o_data;
    assign mcu_measure_o_list = r_o_list;
    assign mcu_measure_o_tmo  = r_o_tmo;
    assign stray_o            = r_stray;

endmodule

// File: tb/tb_qpu_mcu_meas_resp.sv
// -----------------------------------------------------------------------------
// tb_qpu_mcu_meas_resp
// Directed self-checking bench for qpu_mcu_meas_resp (default parameters).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_qpu_mcu_meas_resp;

    logic        clk;
    logic        rst;
    logic        meas_req_valid;
    logic        meas_req_ready;
    logic [11:0] meas_req_list;
    logic [11:0] rdout_valid;
    logic [11:0] rdout_data;
    logic [15:0] tmo_cfg;
    logic        mcu_measure_o_wen;
    logic        mcu_measure_o_ready;
    logic [11:0] mcu_measure_o_data;
    logic [11:0] mcu_measure_o_list;
    logic        mcu_measure_o_tmo;
    logic        stray_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [11:0] exp_lists [4];

    qpu_mcu_meas_resp dut (
        .clk                 (clk),
        .rst                 (rst),
        .meas_req_valid      (meas_req_valid),
        .meas_req_ready      (meas_req_ready),
        .meas_req_list       (meas_req_list),
        .rdout_valid         (rdout_valid),
        .rdout_data          (rdout_data),
        .tmo_cfg             (tmo_cfg),
        .mcu_measure_o_wen   (mcu_measure_o_wen),
        .mcu_measure_o_ready (mcu_measure_o_ready),
        .mcu_measure_o_data  (mcu_measure_o_data),
        .mcu_measure_o_list  (mcu_measure_o_list),
        .mcu_measure_o_tmo   (mcu_measure_o_tmo),
        .stray_o             (stray_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [11:0] lst);
        meas_req_valid = 1'b1;
        meas_req_list  = lst;
        tick;
        meas_req_valid = 1'b0;
        meas_req_list  = 12'h000;
    endtask

    task automatic strobe(input logic [11:0] v, input logic [11:0] d);
        rdout_valid = v;
        rdout_data  = d;
        tick;
        rdout_valid = 12'h000;
        rdout_data  = 12'h000;
    endtask

    initial begin
        exp_lists[0] = 12'h002;
        exp_lists[1] = 12'h004;
        exp_lists[2] = 12'h008;
        exp_lists[3] = 12'h010;

        rst                 = 1'b1;
        meas_req_valid      = 1'b0;
        meas_req_list       = 12'h000;
        rdout_valid         = 12'h000;
        rdout_data          = 12'h000;
        tmo_cfg             = 16'd0;
        mcu_measure_o_ready = 1'b0;
        tick;
        tick;
        tick;

        // Reset state
        chk("rst_ready", 32'(meas_req_ready), 32'd0);
        chk("rst_wen",   32'(mcu_measure_o_wen), 32'd0);
        chk("rst_data",  32'(mcu_measure_o_data), 32'h0);
        chk("rst_list",  32'(mcu_measure_o_list), 32'h0);
        chk("rst_tmo",   32'(mcu_measure_o_tmo), 32'd0);
        chk("rst_stray", 32'(stray_o), 32'd0);
        rst = 1'b0;
        tick;
        chk("post_rst_ready", 32'(meas_req_ready), 32'd1);

        // Two-qubit list, strobes three cycles apart, wen one cycle after last
        mcu_measure_o_ready = 1'b1;
        push(12'h005);
        tick;                                   // pop -> COLLECT
        strobe(12'h001, 12'h001);
        chk("t1_stray_q0", 32'(stray_o), 32'd0);
        tick;
        tick;
        chk("t1_no_early_wen", 32'(mcu_measure_o_wen), 32'd0);
        strobe(12'h004, 12'h000);
        chk("t1_wen",  32'(mcu_measure_o_wen), 32'd1);
        chk("t1_data", 32'(mcu_measure_o_data), 32'h001);
        chk("t1_list", 32'(mcu_measure_o_list), 32'h005);
        chk("t1_tmo",  32'(mcu_measure_o_tmo), 32'd0);
        tick;
        chk("t1_accepted_wen",  32'(mcu_measure_o_wen), 32'd0);
        chk("t1_accepted_data", 32'(mcu_measure_o_data), 32'h0);

        // Timeout after 10 collect cycles, return held for 3 cycles
        mcu_measure_o_ready = 1'b0;
        tmo_cfg = 16'd10;
        push(12'h003);
        tick;                                   // pop -> COLLECT cycle 0
        strobe(12'h001, 12'h001);               // now in collect cycle 1
        for (int i = 0; i < 8; i++) tick;       // collect cycle 9
        chk("t2_no_wen_before_tmo", 32'(mcu_measure_o_wen), 32'd0);
        tick;
        chk("t2_wen",  32'(mcu_measure_o_wen), 32'd1);
        chk("t2_data", 32'(mcu_measure_o_data), 32'h001);
        chk("t2_list", 32'(mcu_measure_o_list), 32'h003);
        chk("t2_tmo",  32'(mcu_measure_o_tmo), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("t2_hold_wen",  32'(mcu_measure_o_wen), 32'd1);
            chk("t2_hold_data", 32'(mcu_measure_o_data), 32'h001);
            chk("t2_hold_list", 32'(mcu_measure_o_list), 32'h003);
            chk("t2_hold_tmo",  32'(mcu_measure_o_tmo), 32'd1);
        end
        mcu_measure_o_ready = 1'b1;
        tick;
        chk("t2_accept_wen", 32'(mcu_measure_o_wen), 32'd0);
        tick;
        chk("t2_single_accept", 32'(mcu_measure_o_wen), 32'd0);
        tmo_cfg = 16'd0;

        // Repeated strobe keeps first value and is not stray; q5 is stray
        push(12'h003);
        tick;
        strobe(12'h001, 12'h001);
        chk("t3_first_stray", 32'(stray_o), 32'd0);
        strobe(12'h001, 12'h000);
        chk("t3_repeat_stray", 32'(stray_o), 32'd0);
        chk("t3_repeat_wen",   32'(mcu_measure_o_wen), 32'd0);
        strobe(12'h020, 12'h020);
        chk("t3_q5_stray", 32'(stray_o), 32'd1);
        chk("t3_q5_wen",   32'(mcu_measure_o_wen), 32'd0);
        strobe(12'h002, 12'h000);
        chk("t3_stray_once", 32'(stray_o), 32'd0);
        chk("t3_wen",  32'(mcu_measure_o_wen), 32'd1);
        chk("t3_data", 32'(mcu_measure_o_data), 32'h001);
        chk("t3_list", 32'(mcu_measure_o_list), 32'h003);
        tick;
        chk("t3_accept_wen", 32'(mcu_measure_o_wen), 32'd0);
        strobe(12'h800, 12'h800);
        chk("t3_idle_stray", 32'(stray_o), 32'd1);
        tick;
        chk("t3_idle_stray_end", 32'(stray_o), 32'd0);

        // All-zero list is dropped
        push(12'h000);
        tick;
        tick;
        chk("t4_zero_list_wen", 32'(mcu_measure_o_wen), 32'd0);
        chk("t4_zero_list_ready", 32'(meas_req_ready), 32'd1);

        // Fill the FIFO while a return is held
        mcu_measure_o_ready = 1'b0;
        push(12'h001);
        tick;
        strobe(12'h001, 12'h001);
        chk("t5_held_wen", 32'(mcu_measure_o_wen), 32'd1);
        push(12'h002);
        chk("t5_ready_after1", 32'(meas_req_ready), 32'd1);
        push(12'h004);
        push(12'h008);
        chk("t5_ready_after3", 32'(meas_req_ready), 32'd1);
        push(12'h010);
        chk("t5_full_ready", 32'(meas_req_ready), 32'd0);
        push(12'h020);                          // ignored
        chk("t5_still_full", 32'(meas_req_ready), 32'd0);
        mcu_measure_o_ready = 1'b1;
        tick;
        chk("t5_release_wen", 32'(mcu_measure_o_wen), 32'd0);
        chk("t5_release_ready", 32'(meas_req_ready), 32'd0);
        tick;                                   // pop 0x002
        chk("t5_pop_ready", 32'(meas_req_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            strobe(exp_lists[i], exp_lists[i]);
            chk("t5_order_wen",  32'(mcu_measure_o_wen), 32'd1);
            chk("t5_order_list", 32'(mcu_measure_o_list), 32'(exp_lists[i]));
            chk("t5_order_data", 32'(mcu_measure_o_data), 32'(exp_lists[i]));
            tick;                               // accepted
            tick;                               // pop next (if any)
        end
        chk("t5_no_fifth_wen", 32'(mcu_measure_o_wen), 32'd0);
        strobe(12'h020, 12'h020);               // idle: stray, not a q5 collect
        chk("t5_fifth_dropped", 32'(stray_o), 32'd1);
        chk("t5_fifth_no_wen", 32'(mcu_measure_o_wen), 32'd0);

        // Reset mid-COLLECT discards everything
        push(12'h00F);
        tick;
        strobe(12'h001, 12'h001);
        rst = 1'b1;
        tick;
        chk("t6_rst_wen",   32'(mcu_measure_o_wen), 32'd0);
        chk("t6_rst_data",  32'(mcu_measure_o_data), 32'h0);
        chk("t6_rst_list",  32'(mcu_measure_o_list), 32'h0);
        chk("t6_rst_tmo",   32'(mcu_measure_o_tmo), 32'd0);
        chk("t6_rst_stray", 32'(stray_o), 32'd0);
        chk("t6_rst_ready", 32'(meas_req_ready), 32'd0);
        rst = 1'b0;
        tick;
        chk("t6_post_ready", 32'(meas_req_ready), 32'd1);
        strobe(12'h00E, 12'h00E);
        chk("t6_no_wen", 32'(mcu_measure_o_wen), 32'd0);
        chk("t6_idle_stray", 32'(stray_o), 32'd1);
        tick;
        chk("t6_no_wen_later", 32'(mcu_measure_o_wen), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
